// File: rtl/qpsk_coherent_demod_if.sv
// Decision output handshake of the QPSK demodulator: hard I/Q bit pair with valid/ready.
// With QPSK_DEMOD_SOFT_OUT_EN defined the final integrator sums travel alongside the bits.
interface qpsk_coherent_demod_if #(
  parameter int ACC_W = 24
);
  logic bit_i;
  logic bit_q;
  logic sym_valid;
  logic sym_ready;
`ifdef QPSK_DEMOD_SOFT_OUT_EN
  logic signed [ACC_W-1:0] soft_i;
  logic signed [ACC_W-1:0] soft_q;
`endif

  modport master (
    output bit_i, bit_q, sym_valid,
`ifdef QPSK_DEMOD_SOFT_OUT_EN
    output soft_i, soft_q,
`endif
    input  sym_ready
  );

  modport slave (
    input  bit_i, bit_q, sym_valid,
`ifdef QPSK_DEMOD_SOFT_OUT_EN
    input  soft_i, soft_q,
`endif
    output sym_ready
  );
endinterface

// File: rtl/qpsk_coherent_demod.sv
// Coherent QPSK demodulator: mixes samples with the carrier table, integrates per symbol,
// emits hard I/Q decisions through a one-deep buffer. Optional soft outputs: QPSK_DEMOD_SOFT_OUT_EN.
module qpsk_coherent_demod #(
  parameter int SAMP_W       = 9,
  parameter int SAMP_PER_SYM = 32,
  parameter int ACC_W        = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      samp_valid,
  input  logic signed [SAMP_W-1:0]  samp,
  input  logic                      sym_sync,
  output logic [6:0]                recev_read,
  input  logic signed [SAMP_W-1:0]  recev_sin,
  input  logic signed [SAMP_W-1:0]  recev_cos,
  qpsk_coherent_demod_if.master     sym,
  output logic                      overrun
);

  localparam int CNT_W = (SAMP_PER_SYM > 1) ? $clog2(SAMP_PER_SYM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMP_PER_SYM - 1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [4:0]                 phase;
  logic [CNT_W-1:0]           cnt;
  logic signed [ACC_W-1:0]    acc_i;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [2*SAMP_W-1:0] prod_i;
  logic signed [2*SAMP_W-1:0] prod_q;
  logic signed [ACC_W-1:0]    sum_i;
  logic signed [ACC_W-1:0]    sum_q;
  logic                       acc_en;
  logic                       last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (sym_sync) state_nxt = ACC;
  end

  // A sample arriving with sym_sync is dropped; the sync restarts the symbol instead.
  always_comb begin
    acc_en = 1'b0;
    last   = 1'b0;
    if (state == ACC && samp_valid && !sym_sync) begin
      acc_en = 1'b1;
      last   = (cnt == CNT_LAST);
    end
  end

  assign prod_i     = samp * recev_cos;
  assign prod_q     = samp * recev_sin;
  assign sum_i      = acc_i + ACC_W'(prod_i);
  assign sum_q      = acc_q + ACC_W'(prod_q);
  assign recev_read = {2'b00, phase};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      cnt   <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else if (sym_sync) begin
      phase <= '0;
      cnt   <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else if (acc_en) begin
      phase <= phase + 5'd1;
      if (last) begin
        cnt   <= '0;
        acc_i <= '0;
        acc_q <= '0;
      end else begin
        cnt   <= cnt + CNT_W'(1);
        acc_i <= sum_i;
        acc_q <= sum_q;
      end
    end
  end

  // One-deep output buffer; an unaccepted pair is overwritten and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym.bit_i     <= 1'b0;
      sym.bit_q     <= 1'b0;
      sym.sym_valid <= 1'b0;
      overrun       <= 1'b0;
`ifdef QPSK_DEMOD_SOFT_OUT_EN
      sym.soft_i    <= '0;
      sym.soft_q    <= '0;
`endif
    end else begin
      if (sym_sync) overrun <= 1'b0;
      if (last) begin
        sym.bit_i     <= sum_i[ACC_W-1];
        sym.bit_q     <= sum_q[ACC_W-1];
        sym.sym_valid <= 1'b1;
`ifdef QPSK_DEMOD_SOFT_OUT_EN
        sym.soft_i    <= sum_i;
        sym.soft_q    <= sum_q;
`endif
        if (sym.sym_valid && !sym.sym_ready) overrun <= 1'b1;
      end else if (sym.sym_valid && sym.sym_ready) begin
        sym.sym_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_coherent_demod.sv
// Self-checking bench for qpsk_coherent_demod: carrier table model, symbol integrator model
// and an expected-decision queue drained on each handshake transfer.
module tb_qpsk_coherent_demod;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              samp_valid = 1'b0;
  logic signed [8:0] samp = '0;
  logic              sym_sync = 1'b0;
  logic [6:0]        recev_read;
  logic signed [8:0] recev_sin;
  logic signed [8:0] recev_cos;
  logic              overrun;

  qpsk_coherent_demod_if #(.ACC_W(24)) sym_if ();

  qpsk_coherent_demod #(
    .SAMP_W(9),
    .SAMP_PER_SYM(32),
    .ACC_W(24)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .samp_valid(samp_valid),
    .samp(samp),
    .sym_sync(sym_sync),
    .recev_read(recev_read),
    .recev_sin(recev_sin),
    .recev_cos(recev_cos),
    .sym(sym_if),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic signed [8:0] tab_cos(input int idx);
    real r;
    r = 255.0 * $cos(2.0 * 3.14159265358979 * idx / 128.0);
    r = (r >= 0.0) ? r + 0.5 : r - 0.5;
    return 9'($rtoi(r));
  endfunction

  function automatic logic signed [8:0] tab_sin(input int idx);
    real r;
    r = 255.0 * $sin(2.0 * 3.14159265358979 * idx / 128.0);
    r = (r >= 0.0) ? r + 0.5 : r - 0.5;
    return 9'($rtoi(r));
  endfunction

  assign recev_cos = tab_cos(4 * int'(recev_read[4:0]));
  assign recev_sin = tab_sin(4 * int'(recev_read[4:0]));

  typedef struct {
    bit     bi;
    bit     bq;
    longint si;
    longint sq;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     n_xfer = 0;
  int     xfer_cyc[$];
  int     m_phase = 0;
  int     m_cnt = 0;
  bit     m_on = 0;
  longint m_acc_i = 0;
  longint m_acc_q = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && sym_if.sym_valid && sym_if.sym_ready) begin
      n_xfer++;
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_sym", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("bit_i", sym_if.bit_i, e.bi);
        check("bit_q", sym_if.bit_q, e.bq);
`ifdef QPSK_DEMOD_SOFT_OUT_EN
        check("soft_i", sym_if.soft_i, e.si);
        check("soft_q", sym_if.soft_q, e.sq);
`endif
      end
    end
  end

  task automatic send(input bit v, input int s, input bit chk_read);
    @(posedge clk);
    #1;
    samp_valid = v;
    samp       = 9'(s);
    sym_sync   = 1'b0;
    @(negedge clk);
    if (chk_read) check("recev_read", recev_read, m_on ? m_phase : 0);
    if (v && m_on) begin
      m_acc_i += longint'(s * int'(tab_cos(4 * m_phase)));
      m_acc_q += longint'(s * int'(tab_sin(4 * m_phase)));
      m_phase = (m_phase + 1) % 32;
      if (m_cnt == 31) begin
        exp_q.push_back('{bi: (m_acc_i < 0), bq: (m_acc_q < 0), si: m_acc_i, sq: m_acc_q});
        m_cnt   = 0;
        m_acc_i = 0;
        m_acc_q = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // The accompanying sample is deliberately non-zero: it must be discarded.
  task automatic do_sync();
    @(posedge clk);
    #1;
    sym_sync   = 1'b1;
    samp_valid = 1'b1;
    samp       = 9'sd200;
    @(posedge clk);
    #1;
    sym_sync   = 1'b0;
    samp_valid = 1'b0;
    m_on    = 1;
    m_phase = 0;
    m_cnt   = 0;
    m_acc_i = 0;
    m_acc_q = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      samp_valid = 1'b0;
      sym_sync   = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    sym_if.sym_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !sym_if.sym_valid) break;
      idle(1);
    end
    check("drain", longint'(exp_q.size()) + longint'(sym_if.sym_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    sym_if.sym_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_recev_read", recev_read, 0);
    check("rst_sym_valid", sym_if.sym_valid, 0);
    check("rst_bit_i", sym_if.bit_i, 0);
    check("rst_bit_q", sym_if.bit_q, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // Idle: samples without a sync are ignored.
    for (int k = 0; k < 64; k++) begin
      send(1, 100, 1);
      check("idle_sym_valid", sym_if.sym_valid, 0);
    end

    // Zero input, decision held until drained.
    do_sync();
    for (int k = 0; k < 32; k++) send(1, 0, 1);
    check("zero_valid_early", sym_if.sym_valid, 0);
    idle(1);
    check("zero_valid", sym_if.sym_valid, 1);
    check("zero_bit_i", sym_if.bit_i, 0);
    check("zero_bit_q", sym_if.bit_q, 0);
    check("zero_read_wrap", recev_read, 0);
    check("zero_overrun", overrun, 0);
    drain();

    // I-axis symbols back to back, sink always ready.
    sym_if.sym_ready = 1'b1;
    do_sync();
    t0 = n_xfer;
    xfer_cyc.delete();
    for (int k = 0; k < 64; k++) begin
      if (k < 32) send(1, -int'(tab_cos(4 * m_phase)), 1);
      else        send(1,  int'(tab_cos(4 * m_phase)), 1);
    end
    idle(2);
    check("iaxis_xfers", n_xfer - t0, 2);
    if (xfer_cyc.size() == 2) check("iaxis_gap", xfer_cyc[1] - xfer_cyc[0], 32);
    else                      check("iaxis_gap_count", xfer_cyc.size(), 2);
    drain();

    // Q-axis with samp_valid low every other cycle; invalid samples carry junk.
    do_sync();
    for (int k = 0; k < 64; k++) begin
      if (k % 2 == 0) send(1, int'(tab_sin(4 * m_phase)), 1);
      else            send(0, -250, 1);
    end
    idle(1);
    drain();

    // Overrun: two symbols with the sink stalled.
    sym_if.sym_ready = 1'b0;
    do_sync();
    for (int k = 0; k < 32; k++) send(1, -int'(tab_cos(4 * m_phase)), 0);
    idle(1);
    check("ovr_valid1", sym_if.sym_valid, 1);
    check("ovr_bit_i1", sym_if.bit_i, 1);
    check("ovr_flag1", overrun, 0);
    for (int k = 0; k < 32; k++) send(1, int'(tab_cos(4 * m_phase)), 0);
    idle(1);
    check("ovr_valid2", sym_if.sym_valid, 1);
    check("ovr_flag2", overrun, 1);
    check("ovr_bit_i2", sym_if.bit_i, 0);
    if (exp_q.size() == 2) begin
      check("ovr_bit_q2", sym_if.bit_q, exp_q[1].bq);
      void'(exp_q.pop_front());
    end else begin
      check("ovr_queue", exp_q.size(), 2);
    end
    do_sync();
    @(negedge clk);
    check("ovr_cleared", overrun, 0);
    check("ovr_valid_kept", sym_if.sym_valid, 1);
    drain();

    // Mid-symbol re-sync: partial symbol produces nothing.
    do_sync();
    for (int k = 0; k < 10; k++) send(1, 150, 1);
    t0 = n_xfer;
    do_sync();
    for (int k = 0; k < 32; k++) send(1, 0, 1);
    idle(2);
    check("resync_xfers", n_xfer - t0, 1);
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
